// File: rtl/bb_output_checker_if.sv
// Bus bundle for bb_output_checker: stimulus/response sample input,
// run control, counters, status and mismatch-log read port.
interface bb_output_checker_if #(
  parameter int CNT_W = 8
);
  // Run control and sample input
  logic             start;
  logic             in_valid;
  logic             a;
  logic             b;
  logic             c;
  logic             d;
  logic             x;
  logic             y;
  logic             log_rd;

  // Status, counters and log read data
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] vec_count;
  logic [CNT_W-1:0] err_count;
  logic             log_empty;
  logic             log_full;
  logic [5:0]       log_data;
  logic             log_overflow;

  // Bench side: drives samples and pops the log
  modport master (
    output start, in_valid, a, b, c, d, x, y, log_rd,
    input  busy, done, pass, vec_count, err_count,
           log_empty, log_full, log_data, log_overflow
  );

  // Checker side
  modport slave (
    input  start, in_valid, a, b, c, d, x, y, log_rd,
    output busy, done, pass, vec_count, err_count,
           log_empty, log_full, log_data, log_overflow
  );
endinterface

// File: rtl/bb_output_checker.sv
// bb_output_checker: self-checking consumer placed downstream of black_box.
// Each accepted sample {a,b,c,d,x,y} is registered (stage 1), then compared
// against x = a | (b & c), y = b & d (stage 2). Mismatches are counted and
// their stage-1 copies are written to a small first-word-fall-through log.
module bb_output_checker #(
  parameter int NUM_VECTORS = 16,
  parameter int CNT_W       = 8,
  parameter int LOG_DEPTH   = 4,
  parameter int LOG_AW      = 2
) (
  input logic               clk,
  input logic               rst,
  bb_output_checker_if.slave bus
);

  // FSM encoding
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [CNT_W-1:0]  CNT_MAX      = '1;
  localparam logic [CNT_W-1:0]  VEC_TARGET   = CNT_W'(NUM_VECTORS);
  localparam logic [LOG_AW:0]   LOG_FULL_CNT = (LOG_AW+1)'(LOG_DEPTH);

  // State and counters
  logic [1:0]        r_state;
  logic              r_drain_cnt;
  logic [CNT_W-1:0]  r_vec_count;
  logic [CNT_W-1:0]  r_err_count;

  // Stage-1 sample copy
  logic              r_s1_valid;
  logic [5:0]        r_s1_data;

  // Mismatch log
  logic [5:0]        r_log_mem [LOG_DEPTH];
  logic [LOG_AW-1:0] r_wr_ptr;
  logic [LOG_AW-1:0] r_rd_ptr;
  logic [LOG_AW:0]   r_log_cnt;
  logic              r_log_overflow;

  // Combinational control
  logic [5:0]        w_sample;
  logic              w_start_taken;
  logic              w_accept;
  logic [CNT_W-1:0]  w_vec_next;
  logic              w_last_accept;
  logic              w_exp_x;
  logic              w_exp_y;
  logic              w_mismatch;
  logic              w_log_empty;
  logic              w_log_full;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;

  assign w_sample      = {bus.a, bus.b, bus.c, bus.d, bus.x, bus.y};

  // start is honoured only from IDLE or DONE; it restarts the run.
  assign w_start_taken = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_accept      = (r_state == S_RUN) && bus.in_valid;
  assign w_vec_next    = (r_vec_count == CNT_MAX) ? r_vec_count : r_vec_count + CNT_W'(1);
  assign w_last_accept = w_accept && (w_vec_next == VEC_TARGET);

  // Stage 2: reference function on the stage-1 copy {a,b,c,d,x,y}.
  assign w_exp_x    = r_s1_data[5] | (r_s1_data[4] & r_s1_data[3]);
  assign w_exp_y    = r_s1_data[4] & r_s1_data[2];
  assign w_mismatch = r_s1_valid && ({w_exp_x, w_exp_y} != r_s1_data[1:0]);

  // A pop frees a slot in the same cycle, so a full log can still accept a
  // write when it is being read; only a write without a pop is dropped.
  assign w_log_empty = (r_log_cnt == '0);
  assign w_log_full  = (r_log_cnt == LOG_FULL_CNT);
  assign w_pop       = bus.log_rd && !w_log_empty;
  assign w_push      = w_mismatch && (!w_log_full || w_pop);
  assign w_drop      = w_mismatch && w_log_full && !w_pop;

  // Run sequencing: IDLE -> RUN -> DRAIN (2 cycles) -> DONE -> RUN ...
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_drain_cnt <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) r_state <= S_RUN;
        end
        S_RUN: begin
          if (w_last_accept) begin
            r_state     <= S_DRAIN;
            r_drain_cnt <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (r_drain_cnt) r_state <= S_DONE;
          else             r_drain_cnt <= 1'b1;
        end
        S_DONE: begin
          if (bus.start) r_state <= S_RUN;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Saturating sample and mismatch counters, cleared by a taken start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vec_count <= '0;
      r_err_count <= '0;
    end else if (w_start_taken) begin
      r_vec_count <= '0;
      r_err_count <= '0;
    end else begin
      if (w_accept) r_vec_count <= w_vec_next;
      if (w_mismatch && (r_err_count != CNT_MAX)) r_err_count <= r_err_count + CNT_W'(1);
    end
  end

  // Stage-1 register: captures the sample on accept, valid for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) r_s1_data <= w_sample;
    end
  end

  // Log pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_log_cnt      <= '0;
      r_log_overflow <= 1'b0;
    end else if (w_start_taken) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_log_cnt      <= '0;
      r_log_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + LOG_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + LOG_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_log_cnt <= r_log_cnt + (LOG_AW+1)'(1);
        2'b01:   r_log_cnt <= r_log_cnt - (LOG_AW+1)'(1);
        default: r_log_cnt <= r_log_cnt;
      endcase
      if (w_drop) r_log_overflow <= 1'b1;
    end
  end

  // Log storage write port.
  // NOTE: the log array has no reset; stale contents are unreachable because
  // the read port is masked to zero whenever the occupancy count is zero.
  always_ff @(posedge clk) begin
    if (w_push && !w_start_taken) r_log_mem[r_wr_ptr] <= r_s1_data;
  end

  // Outputs
  assign bus.busy         = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign bus.done         = (r_state == S_DONE);
  assign bus.pass         = (r_state == S_DONE) && (r_err_count == '0) && !r_log_overflow;
  assign bus.vec_count    = r_vec_count;
  assign bus.err_count    = r_err_count;
  assign bus.log_empty    = w_log_empty;
  assign bus.log_full     = w_log_full;
  assign bus.log_data     = w_log_empty ? 6'd0 : r_log_mem[r_rd_ptr];
  assign bus.log_overflow = r_log_overflow;

endmodule

// File: tb/tb_bb_output_checker.sv
// Self-checking bench for bb_output_checker. A small reference model tracks
// accepted samples, expected mismatch count and a scoreboard queue of the
// log contents; log pops compare the DUT head against the queue front.
module tb_bb_output_checker;

  localparam int NUM_VECTORS = 16;
  localparam int CNT_W       = 8;
  localparam int LOG_DEPTH   = 4;
  localparam int LOG_AW      = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bb_output_checker_if #(.CNT_W(CNT_W)) bus ();

  bb_output_checker #(
    .NUM_VECTORS (NUM_VECTORS),
    .CNT_W       (CNT_W),
    .LOG_DEPTH   (LOG_DEPTH),
    .LOG_AW      (LOG_AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [5:0] sb_q[$];
  int         m_vec;
  int         m_err;
  bit         m_ovf;
  bit         m_run;
  bit         m_pend;
  logic [5:0] m_pend_data;

  function automatic logic [1:0] ref_xy(input logic [3:0] abcd);
    return {abcd[3] | (abcd[2] & abcd[1]), abcd[2] & abcd[0]};
  endfunction

  function automatic logic [5:0] good_vec(input int i);
    logic [3:0] v;
    v = 4'(i);
    return {v, ref_xy(v)};
  endfunction

  task automatic model_clear();
    sb_q.delete();
    m_vec  = 0;
    m_err  = 0;
    m_ovf  = 1'b0;
    m_run  = 1'b0;
    m_pend = 1'b0;
  endtask

  // One clock: drive inputs, compare log head on a pop, advance the model
  // for the edge, then compare counters and log status.
  task automatic step(input bit st, input bit v, input logic [5:0] vec, input bit rd);
    logic [5:0] head;
    bus.start    = st;
    bus.in_valid = v;
    {bus.a, bus.b, bus.c, bus.d, bus.x, bus.y} = vec;
    bus.log_rd   = rd;
    if (rd) begin
      n_cmp++;
      if (sb_q.size() > 0) begin
        head = sb_q[0];
        if (bus.log_data !== head) begin
          n_bad++;
          $display("FAIL log_pop_data: got %b want %b", bus.log_data, head);
        end
      end else if (bus.log_empty !== 1'b1) begin
        n_bad++;
        $display("FAIL log_pop_empty: got %b want 1", bus.log_empty);
      end
    end
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.log_rd   = 1'b0;
    if (rd && sb_q.size() > 0) void'(sb_q.pop_front());
    if (m_pend) begin
      if (m_err < 255) m_err++;
      if (sb_q.size() < LOG_DEPTH) sb_q.push_back(m_pend_data);
      else                         m_ovf = 1'b1;
      m_pend = 1'b0;
    end
    if (st && !m_run) begin
      model_clear();
      m_run = 1'b1;
    end else if (m_run && v) begin
      m_vec++;
      if (vec[1:0] !== ref_xy(vec[5:2])) begin
        m_pend      = 1'b1;
        m_pend_data = vec;
      end
      if (m_vec == NUM_VECTORS) m_run = 1'b0;
    end
    n_cmp++;
    if (bus.vec_count !== CNT_W'(m_vec)) begin
      n_bad++;
      $display("FAIL vec_count: got %0d want %0d", bus.vec_count, m_vec);
    end
    n_cmp++;
    if (bus.err_count !== CNT_W'(m_err)) begin
      n_bad++;
      $display("FAIL err_count: got %0d want %0d", bus.err_count, m_err);
    end
    n_cmp++;
    if (bus.log_overflow !== m_ovf) begin
      n_bad++;
      $display("FAIL log_overflow: got %b want %b", bus.log_overflow, m_ovf);
    end
    n_cmp++;
    if (bus.log_empty !== (sb_q.size() == 0)) begin
      n_bad++;
      $display("FAIL log_empty: got %b want %b", bus.log_empty, sb_q.size() == 0);
    end
  endtask

  // Idle until done, allowing at most max_idle cycles.
  task automatic wait_done(input int max_idle);
    int k;
    k = 0;
    while (bus.done !== 1'b1 && k < max_idle) begin
      step(1'b0, 1'b0, 6'd0, 1'b0);
      k++;
    end
    n_cmp++;
    if (bus.done !== 1'b1) begin
      n_bad++;
      $display("FAIL done_timeout: got done=%b want 1 within %0d cycles", bus.done, max_idle);
    end
  endtask

  task automatic apply_reset();
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    {bus.a, bus.b, bus.c, bus.d, bus.x, bus.y} = 6'd0;
    bus.log_rd   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    logic [7:0] obs;
    apply_reset();
    obs = {bus.busy, bus.done, bus.pass, bus.log_empty, bus.log_full, bus.log_overflow, 2'b00};
    n_cmp++;
    if (obs !== 8'b0001_0000) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 00010000", obs);
    end
    n_cmp++;
    if ({bus.vec_count, bus.err_count, bus.log_data} !== '0) begin
      n_bad++;
      $display("FAIL reset_values: got vec=%0d err=%0d data=%b want 0",
               bus.vec_count, bus.err_count, bus.log_data);
    end
  endtask

  task automatic test_all_correct();
    step(1'b1, 1'b0, 6'd0, 1'b0);
    for (int i = 0; i < NUM_VECTORS; i++) step(1'b0, 1'b1, good_vec(i), 1'b0);
    n_cmp++;
    if ({bus.busy, bus.done, bus.pass} !== 3'b100) begin
      n_bad++;
      $display("FAIL drain_flags: got %b want 100", {bus.busy, bus.done, bus.pass});
    end
    wait_done(3);
    n_cmp++;
    if ({bus.pass, bus.log_empty, bus.busy} !== 3'b110) begin
      n_bad++;
      $display("FAIL clean_run_pass: got %b want 110", {bus.pass, bus.log_empty, bus.busy});
    end
  endtask

  task automatic test_single_fault();
    step(1'b1, 1'b0, 6'd0, 1'b0);
    for (int i = 0; i < NUM_VECTORS; i++) begin
      step(1'b0, 1'b1, (i == 6) ? 6'b011000 : good_vec(i), 1'b0);
      if (i == 7) begin
        n_cmp++;
        if (bus.log_data !== 6'b011000) begin
          n_bad++;
          $display("FAIL single_fault_log: got %b want 011000", bus.log_data);
        end
      end
    end
    wait_done(3);
    n_cmp++;
    if (bus.pass !== 1'b0) begin
      n_bad++;
      $display("FAIL single_fault_pass: got %b want 0", bus.pass);
    end
    step(1'b0, 1'b0, 6'd0, 1'b1);
  endtask

  task automatic test_overflow();
    step(1'b1, 1'b0, 6'd0, 1'b0);
    for (int i = 0; i < NUM_VECTORS; i++) begin
      if (i % 3 == 1) step(1'b0, 1'b1, good_vec(i) ^ ((i % 2 == 1) ? 6'b000010 : 6'b000001), 1'b0);
      else            step(1'b0, 1'b1, good_vec(i), 1'b0);
    end
    wait_done(3);
    n_cmp++;
    if ({bus.log_full, bus.log_overflow, bus.pass} !== 3'b110 || bus.err_count !== 8'd5) begin
      n_bad++;
      $display("FAIL overflow_status: got full/ovf/pass=%b err=%0d want 110 err=5",
               {bus.log_full, bus.log_overflow, bus.pass}, bus.err_count);
    end
    for (int k = 0; k < LOG_DEPTH; k++) step(1'b0, 1'b0, 6'd0, 1'b1);
  endtask

  task automatic test_in_valid_flood();
    step(1'b1, 1'b0, 6'd0, 1'b0);
    for (int c = 0; c < 20; c++) begin
      step(c == 3, 1'b1, good_vec(c % 16), 1'b0);
      if (c == 3) begin
        n_cmp++;
        if (bus.busy !== 1'b1) begin
          n_bad++;
          $display("FAIL start_in_run_busy: got %b want 1", bus.busy);
        end
      end
    end
    wait_done(3);
    n_cmp++;
    if (bus.vec_count !== 8'd16 || bus.pass !== 1'b1) begin
      n_bad++;
      $display("FAIL flood_final: got vec=%0d pass=%b want 16 1", bus.vec_count, bus.pass);
    end
  endtask

  task automatic test_back_to_back();
    step(1'b1, 1'b0, 6'd0, 1'b0);
    for (int i = 0; i < NUM_VECTORS; i++) begin
      if (i < 5) step(1'b0, 1'b1, good_vec(i) ^ 6'b000010, 1'b0);
      else if (i == 5) begin
        n_cmp++;
        if (bus.log_full !== 1'b1) begin
          n_bad++;
          $display("FAIL b2b_full_before: got %b want 1", bus.log_full);
        end
        step(1'b0, 1'b1, good_vec(i), 1'b1);
        n_cmp++;
        if ({bus.log_full, bus.log_overflow} !== 2'b10 || bus.log_data !== (good_vec(1) ^ 6'b000010)) begin
          n_bad++;
          $display("FAIL b2b_pop_write: got full/ovf=%b head=%b want 10 head=%b",
                   {bus.log_full, bus.log_overflow}, bus.log_data, good_vec(1) ^ 6'b000010);
        end
      end
      else step(1'b0, 1'b1, good_vec(i), 1'b0);
    end
    wait_done(3);
    for (int k = 0; k < LOG_DEPTH; k++) step(1'b0, 1'b0, 6'd0, 1'b1);
  endtask

  task automatic test_mid_run_reset();
    step(1'b1, 1'b0, 6'd0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, (i == 2) ? (good_vec(i) ^ 6'b000001) : good_vec(i), 1'b0);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.busy, bus.log_empty} !== 2'b01 || bus.vec_count !== '0 || bus.err_count !== '0) begin
      n_bad++;
      $display("FAIL mid_run_reset: got busy=%b empty=%b vec=%0d err=%0d want 0 1 0 0",
               bus.busy, bus.log_empty, bus.vec_count, bus.err_count);
    end
    #1;
    rst = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 6'd0, 1'b0);
    for (int i = 0; i < NUM_VECTORS; i++) step(1'b0, 1'b1, good_vec(15 - i), 1'b0);
    wait_done(3);
    n_cmp++;
    if (bus.pass !== 1'b1) begin
      n_bad++;
      $display("FAIL post_reset_pass: got %b want 1", bus.pass);
    end
  endtask

  initial begin
    test_reset();
    test_all_correct();
    test_single_fault();
    test_overflow();
    test_in_valid_flood();
    test_back_to_back();
    test_mid_run_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
